// File: rtl/cpu_memory_if.sv
// CPU/loader bus bundle for cpu_memory: CPU fetch/load/store signals plus the
// byte-stream program loader handshake.
interface cpu_memory_if;
    logic [7:0]  PC;
    logic [7:0]  Address_out;
    logic [7:0]  Data_out;
    logic        MW;
    logic [15:0] IR;
    logic [7:0]  Data_in;
    logic        cpu_reset;

    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [8:0]  prog_len;

    // CPU plus loader side
    modport master (
        output PC, Address_out, Data_out, MW,
        output ld_start, ld_valid, ld_data, ld_last,
        input  IR, Data_in, cpu_reset, ld_ready, prog_len
    );

    // Memory side
    modport slave (
        input  PC, Address_out, Data_out, MW,
        input  ld_start, ld_valid, ld_data, ld_last,
        output IR, Data_in, cpu_reset, ld_ready, prog_len
    );
endinterface

// File: rtl/cpu_memory.sv
// Instruction/data memory for a small CPU with a byte-serial program loader.
// The CPU is held in reset until a program load completes.
module cpu_memory #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    cpu_memory_if.slave  bus
);

    localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam int unsigned PTR_W   = 8;
    localparam int unsigned LEN_W   = 9;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [7:0]         hi_byte, hi_byte_next;
    logic [LEN_W-1:0]   prog_len, prog_len_next;
    logic               loading;
    logic               hs;
    logic               imem_we;
    logic               dmem_we;

    logic [15:0] imem [IMEM_DEPTH];
    logic [7:0]  dmem [DMEM_DEPTH];

    assign loading = (state == LOAD_HI) || (state == LOAD_LO);
    assign hs      = loading && bus.ld_valid;
    assign dmem_we = (state == RUN) && bus.MW;

    // Loader control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hi_byte  <= '0;
            prog_len <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            hi_byte  <= hi_byte_next;
            prog_len <= prog_len_next;
        end
    end

    // Next-state and IMEM write decode
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        hi_byte_next  = hi_byte;
        prog_len_next = prog_len;
        imem_we       = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (bus.ld_start) begin
                    state_next    = LOAD_HI;
                    ptr_next      = '0;
                    prog_len_next = '0;
                end
            end
            LOAD_HI: begin
                if (hs) begin
                    hi_byte_next = bus.ld_data;
                    state_next   = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (hs) begin
                    imem_we       = 1'b1;
                    prog_len_next = prog_len + LEN_W'(1);
                    // The final IMEM slot ends the load; the pointer parks there.
                    if (ptr == LAST_PTR) begin
                        state_next = RUN;
                    end else begin
                        ptr_next   = ptr + PTR_W'(1);
                        state_next = bus.ld_last ? RUN : LOAD_HI;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory arrays keep their contents across reset
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[IMEM_AW'(ptr)] <= {hi_byte, bus.ld_data};
        end
        if (dmem_we) begin
            dmem[DMEM_AW'(bus.Address_out)] <= bus.Data_out;
        end
    end

    assign bus.IR        = (state == RUN) ? imem[IMEM_AW'(bus.PC)] : 16'h0000;
    assign bus.Data_in   = dmem[DMEM_AW'(bus.Address_out)];
    assign bus.cpu_reset = (state != RUN);
    assign bus.ld_ready  = loading;
    assign bus.prog_len  = prog_len;

endmodule
